// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty status derived
// from wrap-bit pointers. Write when full and read when empty are silently ignored.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic do_write;
    logic do_read;

    // Status from registered pointers, accepted transfers, and next-state values.
    always_comb begin
        empty    = (wptr_q == rptr_q);
        full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_write = w_en && !full;
        do_read  = r_en && !empty;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        dout_d   = dout_q;
        if (do_write) begin
            wptr_d = wptr_q + (AW + 1)'(1);
        end
        if (do_read) begin
            rptr_d = rptr_q + (AW + 1)'(1);
            dout_d = mem_q[rptr_q[AW-1:0]];
        end
    end

    // Pointer and read-data registers; reset empties the FIFO and clears dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= dout_d;
        end
    end

    // Storage array; contents survive reset and are only written on accepted writes.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table for reset, basic, full and
// simultaneous cases, followed by wrap, steady-state, random and mid-run reset sequences.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [3:0] din;
    logic       r_en;
    logic [3:0] dout;
    logic       full;
    logic       empty;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       w_en;
        logic [3:0] din;
        logic       r_en;
        logic [3:0] exp_dout;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[$];

    sync_fifo #(.DATA_WIDTH(4), .DEPTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .w_en  (w_en),
        .din   (din),
        .r_en  (r_en),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic w, input logic [3:0] d,
                                input logic rd, input logic [3:0] ed,
                                input logic ef, input logic ee);
        vec_t v;
        v.rst = r; v.w_en = w; v.din = d; v.r_en = rd;
        v.exp_dout = ed; v.exp_full = ef; v.exp_empty = ee;
        vecs.push_back(v);
    endfunction

    // Drive inputs just after an edge, clock once, sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [3:0] d, input logic rd);
        w_en = w; din = d; r_en = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] q[$];
        logic [3:0] exp_dout;
        logic [3:0] wr_d;
        logic [3:0] rd_d;
        logic       w, rd, dw, dr;
        logic [3:0] d;

        rst = 1'b0; w_en = 1'b0; din = '0; r_en = 1'b0;

        // Reset held for 5 cycles, then idle.
        for (int i = 0; i < 5; i++) add(1, 0, 4'h0, 0, 4'h0, 0, 1);
        add(0, 0, 4'h0, 0, 4'h0, 0, 1);
        // Three writes, three reads, one extra read on empty.
        add(0, 1, 4'h3, 0, 4'h0, 0, 0);
        add(0, 1, 4'h7, 0, 4'h0, 0, 0);
        add(0, 1, 4'hA, 0, 4'h0, 0, 0);
        add(0, 0, 4'h0, 1, 4'h3, 0, 0);
        add(0, 0, 4'h0, 1, 4'h7, 0, 0);
        add(0, 0, 4'h0, 1, 4'hA, 0, 1);
        add(0, 0, 4'h0, 1, 4'hA, 0, 1);
        // Fill to full, overflow write dropped, drain in order.
        for (int i = 0; i < 8; i++) add(0, 1, 4'(i), 0, 4'hA, (i == 7), 0);
        add(0, 1, 4'hF, 0, 4'hA, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 4'h0, 1, 4'(i), 0, (i == 7));
        // Full with simultaneous read/write: pop only; then drain; then empty with both.
        for (int i = 1; i <= 8; i++) add(0, 1, 4'(i), 0, 4'h7, (i == 8), 0);
        add(0, 1, 4'hE, 1, 4'h1, 0, 0);
        for (int i = 2; i <= 8; i++) add(0, 0, 4'h0, 1, 4'(i), 0, (i == 8));
        add(0, 1, 4'h9, 1, 4'h8, 0, 0);
        add(0, 0, 4'h0, 1, 4'h9, 0, 1);

        #2 rst = 1'b1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            cycle(vecs[i].w_en, vecs[i].din, vecs[i].r_en);
            check4($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
            check1($sformatf("vec%0d full", i), full, vecs[i].exp_full);
            check1($sformatf("vec%0d empty", i), empty, vecs[i].exp_empty);
        end

        // Wrap: 20 x (write 5, read 5), pointers cross the wrap boundary many times.
        wr_d = 4'h0;
        rd_d = 4'h0;
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 5; k++) begin
                cycle(1, wr_d, 0);
                wr_d = wr_d + 4'h1;
                check1($sformatf("wrap%0d wr full", it), full, 1'b0);
            end
            for (int k = 0; k < 5; k++) begin
                cycle(0, 4'h0, 1);
                check4($sformatf("wrap%0d rd%0d dout", it, k), dout, rd_d);
                rd_d = rd_d + 4'h1;
                check1($sformatf("wrap%0d rd full", it), full, 1'b0);
            end
            check1($sformatf("wrap%0d empty", it), empty, 1'b1);
        end
        exp_dout = rd_d - 4'h1;

        // Steady state: 4 stored, 10 cycles of simultaneous read and write.
        q.delete();
        for (int k = 0; k < 4; k++) begin
            cycle(1, 4'(k + 4), 0);
            q.push_back(4'(k + 4));
        end
        check4("steady pre dout", dout, exp_dout);
        for (int k = 0; k < 10; k++) begin
            d = 4'(k + 8);
            cycle(1, d, 1);
            exp_dout = q.pop_front();
            q.push_back(d);
            check4($sformatf("steady%0d dout", k), dout, exp_dout);
            check1($sformatf("steady%0d full", k), full, 1'b0);
            check1($sformatf("steady%0d empty", k), empty, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 4'h0, 1);
            exp_dout = q.pop_front();
            check4($sformatf("steady drain%0d dout", k), dout, exp_dout);
        end
        check1("steady drained empty", empty, 1'b1);

        // Random traffic against a queue model, with an asynchronous reset mid-run.
        q.delete();
        for (int c = 0; c < 50; c++) begin
            if (c == 25) begin
                rst = 1'b1;
                #1;
                check1("midrst empty", empty, 1'b1);
                check1("midrst full", full, 1'b0);
                check4("midrst dout", dout, 4'h0);
                q.delete();
                exp_dout = 4'h0;
                cycle(0, 4'h0, 0);
                rst = 1'b0;
                check1("midrst held empty", empty, 1'b1);
            end
            w  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            d  = 4'($urandom_range(0, 15));
            dw = w && (q.size() < 8);
            dr = rd && (q.size() > 0);
            cycle(dw, d, dr);
            if (dr) exp_dout = q.pop_front();
            if (dw) q.push_back(d);
            check4($sformatf("rand%0d dout", c), dout, exp_dout);
            check1($sformatf("rand%0d full", c), full, (q.size() == 8));
            check1($sformatf("rand%0d empty", c), empty, (q.size() == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
